// File: rtl/morse_pkg.sv
// Shared types and default timing for the Morse sequencer slice.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECIDE,
    KEY_ON,
    SYM_GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

  // Symbol encoding as presented by the code shift register MSB.
  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  localparam int UNIT_CYCLES_DEF    = 4;
  localparam int DASH_UNITS_DEF     = 3;
  localparam int CHAR_GAP_UNITS_DEF = 3;
  localparam int WORD_GAP_UNITS_DEF = 4;

  // Largest of three unit counts; sizes the unit down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/morse_seq_ctrl_if.sv
// Character handshake and shift-register link between the source, the
// code shift register and the Morse sequencer.
interface morse_seq_ctrl_if;
  logic       char_valid;
  logic       char_ready;
  logic       char_load;
  logic       shft_cnt;
  logic [3:0] cntr_data;
  logic       shft_data;
  logic       morse_out;
  logic       busy;

  // Environment side: character source plus shift register.
  modport master (
    output char_valid, cntr_data, shft_data,
    input  char_ready, char_load, shft_cnt, morse_out, busy
  );

  // Sequencer side.
  modport slave (
    input  char_valid, cntr_data, shft_data,
    output char_ready, char_load, shft_cnt, morse_out, busy
  );
endinterface

// File: rtl/morse_unit_timer.sv
// Unit timer: prescaler of UNIT_CYCLES clocks feeding a down-counter of
// units. restart reloads both; done is high on the final clock of the span.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 4,
  parameter int UW          = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          restart,
  input  logic [UW-1:0] load_units,
  output logic          done
);

  localparam int PW = $clog2(UNIT_CYCLES);

  logic [PW-1:0] presc_q;
  logic [UW-1:0] unit_q;

  logic presc_tc;
  assign presc_tc = (presc_q == PW'(UNIT_CYCLES - 1));
  assign done     = presc_tc && (unit_q == '0);

  // Prescaler wraps every unit; unit counter counts down to its terminal count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      unit_q  <= '0;
    end else if (restart) begin
      presc_q <= '0;
      unit_q  <= load_units - UW'(1);
    end else if (presc_tc) begin
      presc_q <= '0;
      if (unit_q != '0) unit_q <= unit_q - UW'(1);
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

endmodule

// File: rtl/morse_seq_ctrl.sv
// Morse sequencer: accepts a character, then keys its symbols MSB-first
// with standard unit timing while stepping the code shift register.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a character; char_load follows char_valid
// DECIDE   | register just loaded; zero length -> word gap, else key
// KEY_ON   | symbol sounding (1 unit dot / DASH_UNITS dash); shift at end
// SYM_GAP  | 1 unit silence between symbols of one character
// CHAR_GAP | silence after the last symbol, then back to IDLE
// WORD_GAP | silence for a space character, then back to IDLE
module morse_seq_ctrl
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES    = UNIT_CYCLES_DEF,
  parameter int DASH_UNITS     = DASH_UNITS_DEF,
  parameter int CHAR_GAP_UNITS = CHAR_GAP_UNITS_DEF,
  parameter int WORD_GAP_UNITS = WORD_GAP_UNITS_DEF
) (
  input logic             clock,
  input logic             reset_n,
  morse_seq_ctrl_if.slave bus
);

  localparam int UW = $clog2(max3(DASH_UNITS, CHAR_GAP_UNITS, WORD_GAP_UNITS) + 1);

  state_t        state_q, state_d;
  logic          sym_q, sym_d;
  logic          morse_q;
  logic          tmr_restart;
  logic          tmr_done;
  logic [UW-1:0] tmr_load;

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES),
    .UW          (UW)
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .restart    (tmr_restart),
    .load_units (tmr_load),
    .done       (tmr_done)
  );

  // State, latched symbol and the registered key output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sym_q   <= DOT;
      morse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      morse_q <= (state_d == KEY_ON);
    end
  end

  // Next state, strobes, and timer reload on every state change.
  always_comb begin
    state_d       = state_q;
    sym_d         = sym_q;
    bus.char_load = 1'b0;
    bus.shft_cnt  = 1'b0;
    tmr_load      = UW'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.char_valid) begin
          bus.char_load = 1'b1;
          state_d       = DECIDE;
        end
      end
      DECIDE: begin
        if (bus.cntr_data == 4'd0) begin
          state_d = WORD_GAP;
        end else begin
          sym_d   = bus.shft_data;
          state_d = KEY_ON;
        end
      end
      KEY_ON: begin
        if (tmr_done) begin
          bus.shft_cnt = 1'b1;
          // Count is sampled before the shift register applies the decrement.
          state_d = (bus.cntr_data == 4'd1) ? CHAR_GAP : SYM_GAP;
        end
      end
      SYM_GAP: begin
        if (tmr_done) begin
          sym_d   = bus.shft_data;
          state_d = KEY_ON;
        end
      end
      CHAR_GAP: begin
        if (tmr_done) state_d = IDLE;
      end
      WORD_GAP: begin
        if (tmr_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    tmr_restart = (state_d != state_q);
    unique case (state_d)
      KEY_ON:   tmr_load = (sym_d == DASH) ? UW'(DASH_UNITS) : UW'(1);
      CHAR_GAP: tmr_load = UW'(CHAR_GAP_UNITS);
      WORD_GAP: tmr_load = UW'(WORD_GAP_UNITS);
      default:  tmr_load = UW'(1);
    endcase
  end

  assign bus.char_ready = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.morse_out  = morse_q;

endmodule

// File: doc/morse_seq_ctrl.md
Name: morse_seq_ctrl

Overview:
Sequencer FSM for the Morse encoder's code shift register. It accepts one character per valid/ready handshake and pulses the register's load. It then walks the symbols MSB-first using the register's shift-and-count strobe, and drives the keyed Morse output with standard unit timing. It sits between the character source (keyboard/ROM lookup) and the code shift register.

Parameters:
UNIT_CYCLES, 4, clock cycles per Morse time unit (≥2); prescaler width = clog2(UNIT_CYCLES).
DASH_UNITS, 3, key-on length of a dash in units (dot fixed at 1).
CHAR_GAP_UNITS, 3, key-off gap after the last symbol of a character.
WORD_GAP_UNITS, 4, key-off time for a zero-length (space) character; added on top of the preceding char gap, giving 7 units total.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
char_valid  in  1  source has a character ready (code/len presented to the shift register).
char_ready  out  1  controller accepts a character this cycle (high only in IDLE).
char_load  out  1  load strobe to the shift register; equals char_valid & char_ready.
shft_cnt  out  1  one-cycle shift-and-decrement strobe to the shift register.
cntr_data  in  4  remaining-symbol count from the shift register.
shft_data  in  1  current symbol from the shift register MSB (0 = dot, 1 = dash).
morse_out  out  1  keyed output, high while a dot/dash is sounding.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, async, any state: state=IDLE, prescaler=0, unit counter=0, symbol latch=0.
- Reset output values: char_ready=1, char_load=0, shft_cnt=0, morse_out=0, busy=0.
- Timing: prescaler restarts at 0 on every state entry. A state lasting N units occupies exactly N*UNIT_CYCLES clocks.
- IDLE: char_ready=1. On char_valid, char_load=1 in the same cycle; next state DECIDE. With char_valid=0, stay in IDLE.
- DECIDE (1 cycle, shift register now holds the loaded data):
  - cntr_data==0 → WORD_GAP.
  - Otherwise latch shft_data → sym, go to KEY_ON.
- KEY_ON: morse_out=1. Duration 1 unit (sym=0) or DASH_UNITS (sym=1).
  - On its final cycle, shft_cnt=1 for exactly one cycle.
  - Next state: CHAR_GAP if cntr_data==1 (sampled pre-decrement), else SYM_GAP.
- SYM_GAP: morse_out=0, 1 unit. On its final cycle, latch shft_data (already shifted) → sym, go to KEY_ON.
- CHAR_GAP: morse_out=0, CHAR_GAP_UNITS units, then IDLE.
- WORD_GAP: morse_out=0, WORD_GAP_UNITS units, no shft_cnt, then IDLE.
- morse_out is a registered decode of state: high exactly in KEY_ON cycles, glitch-free.
- First key-on cycle is 2 clocks after the accepting edge.
- char_valid while busy is ignored; char_ready=0 and char_load=0 throughout.
- Lengths 9–15 are sent as given: symbols beyond the 8th read 0 from the register and are keyed as dots. Exactly cntr_data symbols are sent; shft_cnt pulses cntr_data times per character.
- Reset mid-symbol: morse_out drops asynchronously; no further shft_cnt. The shift register is cleared by its own reset path.
- Back-to-back characters: IDLE lasts ≥1 cycle between characters. With char_valid held high, the next accept occurs on the first IDLE cycle.

Decomposition:
- Shared package (morse_pkg):
  - State enum: IDLE, DECIDE, KEY_ON, SYM_GAP, CHAR_GAP, WORD_GAP.
  - Symbol encoding constants: DOT=0, DASH=1.
  - Default unit constants.
- Sub-module morse_unit_timer: prescaler plus unit counter, with restart input, load value in units, and a done pulse on the final cycle. The FSM instantiates it once.

Test Plan:
- UNIT_CYCLES=4, 'E' (code 8'h00, len 1) accepted at cycle 0 → DECIDE at 1; morse_out=1 cycles 2–5; shft_cnt at cycle 5; low 6–17; char_ready=1 at 18.
- 'A' (code 8'h40, len 2) → morse_out high 4, low 4, high 12, low 12; shft_cnt twice; busy=1 throughout.
- Zero length (len 0) → morse_out stays 0; busy for 1+16 cycles; no shft_cnt pulses.
- char_valid held high with 'T' then 'E' → second char_load occurs exactly on the first IDLE cycle after the 12-cycle char gap; inputs asserted mid-character are ignored.
- reset_n low during the 2nd cycle of a dash → morse_out=0 and busy=0 immediately; after release, IDLE with char_ready=1.
- Length 10 with code 8'hFF → 8 dashes then 2 dots; shft_cnt pulses exactly 10 times.
